// File: rtl/operand_queue_if.sv
// Operand queue bus: issue-side doorbells and operand set in, FPU-side head entry out.
// Ports: fpu_rst_w/fpu_doorbell_w/simd_doorbell/enable/operands_in from issue logic,
//        in_ready/operands_out/out_valid/count back, out_ready from the FPU core.
// Optional macro OPQ_OVERFLOW_FLAG_EN adds ovf_clr (in) and overflow (out).
interface operand_queue_if #(
    parameter int DATA_W       = 32,
    parameter int NUM_OPERANDS = 2,
    parameter int DEPTH        = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                           fpu_rst_w;
    logic                           fpu_doorbell_w;
    logic                           simd_doorbell;
    logic                           enable;
    logic [NUM_OPERANDS*DATA_W-1:0] operands_in;
    logic                           in_ready;
    logic [NUM_OPERANDS*DATA_W-1:0] operands_out;
    logic                           out_valid;
    logic                           out_ready;
    logic [CNT_W-1:0]               count;
`ifdef OPQ_OVERFLOW_FLAG_EN
    logic                           ovf_clr;
    logic                           overflow;
`endif

    // Issue logic + FPU core side.
    modport master (
        output fpu_rst_w, fpu_doorbell_w, simd_doorbell, enable, operands_in, out_ready,
        input  in_ready, operands_out, out_valid, count
`ifdef OPQ_OVERFLOW_FLAG_EN
        , output ovf_clr, input overflow
`endif
    );

    // The queue itself.
    modport slave (
        input  fpu_rst_w, fpu_doorbell_w, simd_doorbell, enable, operands_in, out_ready,
        output in_ready, operands_out, out_valid, count
`ifdef OPQ_OVERFLOW_FLAG_EN
        , input ovf_clr, output overflow
`endif
    );
endinterface

// File: rtl/operand_queue.sv
// Operand queue: buffers up to DEPTH operand sets captured on FPU/SIMD doorbells and
// presents the oldest set to the FPU through out_valid/out_ready.
// Ports: clk, reset (async, active-high), bus (operand_queue_if.slave).
// Latency 1 cycle push-to-out_valid (no bypass); pushes while full without a pop are dropped.
// Optional macro OPQ_OVERFLOW_FLAG_EN adds a sticky overflow flag with ovf_clr.
module operand_queue #(
    parameter int DATA_W       = 32,
    parameter int NUM_OPERANDS = 2,
    parameter int DEPTH        = 4
) (
    input logic           clk,
    input logic           reset,
    operand_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SET_W = NUM_OPERANDS * DATA_W;

    typedef logic [SET_W-1:0] set_t;

    set_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic flush;
    logic push_req;
    logic push;
    logic pop;

    // Handshake flags come from the registered count only, so out_ready never
    // reaches in_ready combinationally.
    assign bus.out_valid    = (count_q != '0);
    assign bus.in_ready     = (count_q != CNT_W'(DEPTH));
    assign bus.count        = count_q;
    assign bus.operands_out = mem_q[rd_ptr_q];

    // A soft-reset doorbell is a flush, never a push, regardless of enable.
    assign flush    = bus.fpu_rst_w & bus.fpu_doorbell_w;
    assign push_req = (bus.fpu_doorbell_w | bus.simd_doorbell) & bus.enable & ~flush;
    assign pop      = bus.out_valid & bus.out_ready;
    // When full, the slot freed by a same-cycle pop can be reused.
    assign push     = push_req & (bus.in_ready | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Leave exactly one zero entry at slot 0.
            rd_ptr_d = '0;
            wr_ptr_d = PTR_W'(1);
            count_d  = CNT_W'(1);
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (flush) begin
                mem_q[0] <= '0;
            end else if (push) begin
                mem_q[wr_ptr_q] <= bus.operands_in;
            end
        end
    end

`ifdef OPQ_OVERFLOW_FLAG_EN
    logic drop;
    logic ovf_q, ovf_d;

    assign drop = push_req & ~bus.in_ready & ~pop;

    // A new drop beats a same-cycle clear; flush leaves the flag alone.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.overflow = ovf_q;
`endif
endmodule

// File: tb/tb_operand_queue.sv
module tb_operand_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    operand_queue_if #(.DATA_W(32), .NUM_OPERANDS(2), .DEPTH(4)) ia ();
    operand_queue_if #(.DATA_W(32), .NUM_OPERANDS(3), .DEPTH(3)) ib ();

    operand_queue #(.DATA_W(32), .NUM_OPERANDS(2), .DEPTH(4)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ia)
    );
    operand_queue #(.DATA_W(32), .NUM_OPERANDS(3), .DEPTH(3)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ib)
    );

    // Reference models: plain FIFOs of operand sets plus a sticky flag.
    logic [63:0] mq_a [$];
    logic [95:0] mq_b [$];
    bit          ovf_a;

    task automatic idle_a();
        ia.fpu_rst_w = 0; ia.fpu_doorbell_w = 0; ia.simd_doorbell = 0;
        ia.enable = 0; ia.operands_in = '0; ia.out_ready = 0;
`ifdef OPQ_OVERFLOW_FLAG_EN
        ia.ovf_clr = 0;
`endif
    endtask

    task automatic idle_b();
        ib.fpu_rst_w = 0; ib.fpu_doorbell_w = 0; ib.simd_doorbell = 0;
        ib.enable = 0; ib.operands_in = '0; ib.out_ready = 0;
`ifdef OPQ_OVERFLOW_FLAG_EN
        ib.ovf_clr = 0;
`endif
    endtask

    // Advance one clock on instance A, applying the queue rules to the model.
    task automatic tick_a();
        bit fl, req, full, pp, clr;
        @(posedge clk);
        fl  = ia.fpu_rst_w & ia.fpu_doorbell_w;
        clr = 0;
`ifdef OPQ_OVERFLOW_FLAG_EN
        clr = ia.ovf_clr;
`endif
        if (fl) begin
            mq_a.delete();
            mq_a.push_back(64'h0);
            if (clr) ovf_a = 0;
        end else begin
            req  = (ia.fpu_doorbell_w | ia.simd_doorbell) & ia.enable;
            full = (mq_a.size() == 4);
            pp   = (mq_a.size() != 0) && ia.out_ready;
            if (pp) void'(mq_a.pop_front());
            if (req && (!full || pp)) mq_a.push_back(ia.operands_in);
            if (req && full && !pp) ovf_a = 1;
            else if (clr) ovf_a = 0;
        end
        #1;
    endtask

    task automatic tick_b();
        bit fl, req, full, pp;
        @(posedge clk);
        fl = ib.fpu_rst_w & ib.fpu_doorbell_w;
        if (fl) begin
            mq_b.delete();
            mq_b.push_back(96'h0);
        end else begin
            req  = (ib.fpu_doorbell_w | ib.simd_doorbell) & ib.enable;
            full = (mq_b.size() == 3);
            pp   = (mq_b.size() != 0) && ib.out_ready;
            if (pp) void'(mq_b.pop_front());
            if (req && (!full || pp)) mq_b.push_back(ib.operands_in);
        end
        #1;
    endtask

    task automatic reset_a();
        idle_a();
        rst_a = 1;
        mq_a.delete();
        ovf_a = 0;
        @(posedge clk); #1;
        rst_a = 0;
    endtask

    task automatic test_reset();
        idle_a();
        idle_b();
        rst_a = 1;
        rst_b = 1;
        mq_a.delete();
        mq_b.delete();
        ovf_a = 0;
        #3;
        checks++; if (ia.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ia.count); end
        checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ia.out_valid); end
        checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ia.in_ready); end
        checks++; if (ia.operands_out !== 64'h0) begin errors++; $display("FAIL reset_operands_out got %h want 0", ia.operands_out); end
        checks++; if (ib.operands_out !== 96'h0) begin errors++; $display("FAIL reset_operands_out_b got %h want 0", ib.operands_out); end
`ifdef OPQ_OVERFLOW_FLAG_EN
        checks++; if (ia.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", ia.overflow); end
`endif
        @(posedge clk); #1;
        rst_a = 0;
        rst_b = 0;
    endtask

    task automatic test_single_push();
        reset_a();
        ia.fpu_doorbell_w = 1;
        ia.enable         = 1;
        ia.operands_in    = {32'h4000_0000, 32'h3F80_0000};
        tick_a();
        idle_a();
        checks++; if (ia.count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", ia.count); end
        checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", ia.out_valid); end
        checks++; if (ia.operands_out !== {32'h4000_0000, 32'h3F80_0000}) begin
            errors++; $display("FAIL single_data got %h want 400000003f800000", ia.operands_out);
        end
    endtask

    task automatic test_fill_drop_drain();
        reset_a();
        ia.simd_doorbell = 1;
        ia.enable        = 1;
        for (int v = 1; v <= 4; v++) begin
            ia.operands_in = {32'h0, 32'(v)};
            tick_a();
        end
        checks++; if (ia.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", ia.count); end
        checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", ia.in_ready); end
        ia.operands_in = {32'h0, 32'd5};
        tick_a();
        checks++; if (ia.count !== 3'd4) begin errors++; $display("FAIL drop_count got %0d want 4", ia.count); end
`ifdef OPQ_OVERFLOW_FLAG_EN
        checks++; if (ia.overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow got %b want 1", ia.overflow); end
`endif
        idle_a();
        ia.out_ready = 1;
        for (int v = 1; v <= 4; v++) begin
            checks++; if (ia.operands_out[31:0] !== 32'(v) || ia.out_valid !== 1'b1) begin
                errors++; $display("FAIL drain_order got %0d (valid %b) want %0d", ia.operands_out[31:0], ia.out_valid, v);
            end
            tick_a();
        end
        checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got valid %b want 0", ia.out_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] exp [4];
        reset_a();
        ia.simd_doorbell = 1;
        ia.enable        = 1;
        for (int i = 0; i < 4; i++) begin
            exp[i]         = {$urandom, $urandom};
            ia.operands_in = exp[i];
            tick_a();
        end
        ia.operands_in = 64'd9;
        ia.out_ready   = 1;
        tick_a();
        checks++; if (ia.count !== 3'd4) begin errors++; $display("FAIL fullpp_count got %0d want 4", ia.count); end
        ia.simd_doorbell = 0;
        for (int i = 1; i <= 4; i++) begin
            logic [63:0] want;
            want = (i < 4) ? exp[i] : 64'd9;
            checks++; if (ia.operands_out !== want) begin
                errors++; $display("FAIL fullpp_order idx %0d got %h want %h", i, ia.operands_out, want);
            end
            tick_a();
        end
        checks++; if (ia.count !== 3'd0) begin errors++; $display("FAIL fullpp_end_count got %0d want 0", ia.count); end
    endtask

    task automatic test_flush();
        reset_a();
        ia.simd_doorbell = 1;
        ia.enable        = 1;
        for (int i = 0; i < 3; i++) begin
            ia.operands_in = {$urandom, $urandom} | 64'h1;
            tick_a();
        end
        // Flush with a competing push and pop, enable low.
        ia.fpu_rst_w      = 1;
        ia.fpu_doorbell_w = 1;
        ia.enable         = 0;
        ia.out_ready      = 1;
        tick_a();
        idle_a();
        checks++; if (ia.count !== 3'd1) begin errors++; $display("FAIL flush_count got %0d want 1", ia.count); end
        checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b want 1", ia.out_valid); end
        checks++; if (ia.operands_out !== 64'h0) begin errors++; $display("FAIL flush_data got %h want 0", ia.operands_out); end
    endtask

    task automatic test_enable();
        logic [63:0] d1, d2;
        reset_a();
        d1 = {$urandom, $urandom};
        d2 = ~d1;
        ia.simd_doorbell = 1; ia.enable = 1; ia.operands_in = d1;
        tick_a();
        ia.fpu_doorbell_w = 1; ia.enable = 0; ia.operands_in = d2;
        tick_a();
        checks++; if (ia.count !== 3'd1) begin errors++; $display("FAIL enable_off_count got %0d want 1", ia.count); end
        checks++; if (ia.operands_out !== d1) begin errors++; $display("FAIL enable_off_data got %h want %h", ia.operands_out, d1); end
        ia.enable = 1;
        tick_a();
        idle_a();
        checks++; if (ia.count !== 3'd2) begin errors++; $display("FAIL enable_both_count got %0d want 2", ia.count); end
        ia.out_ready = 1;
        tick_a();
        idle_a();
        checks++; if (ia.operands_out !== d2 || ia.count !== 3'd1) begin
            errors++; $display("FAIL enable_both_data got %h cnt %0d want %h cnt 1", ia.operands_out, ia.count, d2);
        end
    endtask

    task automatic test_random_a();
        reset_a();
        for (int n = 0; n < 400; n++) begin
            ia.fpu_doorbell_w = ($urandom_range(3) == 0);
            ia.simd_doorbell  = ($urandom_range(2) == 0);
            ia.enable         = ($urandom_range(3) != 0);
            ia.fpu_rst_w      = ($urandom_range(19) == 0);
            ia.out_ready      = ($urandom_range(2) == 0);
            ia.operands_in    = {$urandom, $urandom};
`ifdef OPQ_OVERFLOW_FLAG_EN
            ia.ovf_clr        = ($urandom_range(7) == 0);
`endif
            tick_a();
            checks++; if (ia.count !== 3'(mq_a.size()) || ia.out_valid !== (mq_a.size() != 0) ||
                          ia.in_ready !== (mq_a.size() != 4)) begin
                errors++; $display("FAIL rand_state cyc %0d got cnt %0d v %b r %b want cnt %0d", n, ia.count, ia.out_valid, ia.in_ready, mq_a.size());
            end
            if (mq_a.size() != 0) begin
                checks++; if (ia.operands_out !== mq_a[0]) begin
                    errors++; $display("FAIL rand_head cyc %0d got %h want %h", n, ia.operands_out, mq_a[0]);
                end
            end
`ifdef OPQ_OVERFLOW_FLAG_EN
            checks++; if (ia.overflow !== ovf_a) begin errors++; $display("FAIL rand_overflow cyc %0d got %b want %b", n, ia.overflow, ovf_a); end
`endif
        end
        idle_a();
    endtask

    task automatic test_wrap_b();
        idle_b();
        rst_b = 1; mq_b.delete();
        @(posedge clk); #1;
        rst_b = 0;
        for (int n = 0; n < 10; n++) begin
            ib.simd_doorbell = 1;
            ib.enable        = 1;
            ib.out_ready     = (n >= 2);
            ib.operands_in   = {$urandom, $urandom, $urandom};
            tick_b();
            checks++; if (ib.count !== 2'(mq_b.size()) || ib.count > 2'd3) begin
                errors++; $display("FAIL wrap_count cyc %0d got %0d want %0d", n, ib.count, mq_b.size());
            end
            if (mq_b.size() != 0) begin
                checks++; if (ib.operands_out !== mq_b[0]) begin
                    errors++; $display("FAIL wrap_head cyc %0d got %h want %h", n, ib.operands_out, mq_b[0]);
                end
            end
        end
        // Reset asserted between edges must clear state without waiting for a clock.
        rst_b = 1;
        mq_b.delete();
        #2;
        checks++; if (ib.count !== 2'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", ib.count); end
        checks++; if (ib.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", ib.out_valid); end
        checks++; if (ib.operands_out !== 96'h0) begin errors++; $display("FAIL midreset_data got %h want 0", ib.operands_out); end
        idle_b();
        @(posedge clk); #1;
        rst_b = 0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_drop_drain();
        test_full_push_pop();
        test_flush();
        test_enable();
        test_random_a();
        test_wrap_b();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_queue.md
Name: operand_queue

Overview:
- Parametrised successor to the two-operand FPU input register.
- Captures NUM_OPERANDS operands of DATA_W bits each on an FPU or SIMD doorbell.
- Buffers up to DEPTH operand sets in a FIFO.
- Presents the oldest set to the FPU datapath through a valid/ready handshake, replacing the single-cycle doorbell pulse.
- Sits between the register-file/SIMD issue logic and the FPU core.

Parameters:
- DATA_W, 32: width of one operand.
- NUM_OPERANDS, 2: operands per set (1..4).
- DEPTH, 4: number of buffered operand sets (>=2; need not be a power of two).
- CNT_W, $clog2(DEPTH+1): width of occupancy count (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- fpu_rst_w  input  1  FPU soft-reset request; qualified by fpu_doorbell_w.
- fpu_doorbell_w  input  1  FPU issue strobe.
- simd_doorbell  input  1  SIMD issue strobe.
- enable  input  1  capture enable for doorbells.
- operands_in  input  NUM_OPERANDS*DATA_W  operand set; operand k at bits [k*DATA_W +: DATA_W].
- in_ready  output  1  high when count < DEPTH.
- operands_out  output  NUM_OPERANDS*DATA_W  head entry of the queue.
- out_valid  output  1  high when count > 0.
- out_ready  input  1  FPU core accepts the head entry.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset (async, while reset=1):
  - Pointers and count go to 0; out_valid=0, in_ready=1, count=0.
  - All storage entries are zeroed, so operands_out=0.
  - Reset asserted mid-transfer discards all entries immediately; no pending pop completes.
- push_req = (fpu_doorbell_w | simd_doorbell) & enable & ~(fpu_rst_w & fpu_doorbell_w).
- pop = out_valid & out_ready.
- push = push_req & (in_ready | pop). Pushing while full is legal only when a pop occurs in the same cycle.
- Flush (fpu_rst_w & fpu_doorbell_w, independent of enable):
  - Next cycle the queue holds exactly one all-zero entry: count=1, out_valid=1, operands_out=0.
  - Any pop or push in that cycle is ignored.
  - Flush has priority over everything except reset.
- Push writes operands_in to mem[wr_ptr], and wr_ptr advances.
- Pop advances rd_ptr.
- Both pointers wrap from DEPTH-1 to 0 (explicit compare, not power-of-two masking).
- Occupancy update:
  - Simultaneous push and pop: count unchanged.
  - Push only: count+1.
  - Pop only: count-1.
- Empty with simultaneous push: no pop can occur (out_valid=0). Data appears on operands_out with out_valid=1 one cycle after the push (latency 1, no bypass).
- push_req while full with no pop: the set is dropped, and queue state is unchanged.
- fpu_doorbell_w and simd_doorbell together (without fpu_rst_w) count as one push of operands_in.
- operands_out is driven directly from mem[rd_ptr] (no output register).
  - It is stable while out_valid=1 and out_ready=0.
  - When empty it is don't-care to consumers, but must not be X after reset.
- in_ready and out_valid are decoded from count only; there is no combinational path from out_ready to in_ready.

Optional Feature:
- Macro: OPQ_OVERFLOW_FLAG_EN.
- Defined: adds input ovf_clr (1 bit) and output overflow (1 bit).
  - overflow resets to 0.
  - It is set the cycle after a dropped push (push_req=1, count=DEPTH, pop=0).
  - It stays set until ovf_clr=1 or reset. If ovf_clr and a new drop occur in the same cycle, set wins.
  - Flush does not clear overflow.
- Undefined: neither port exists, and dropped pushes are silent.

Test Plan:
- Reset, then fpu_doorbell_w=1, enable=1, operands_in={32'h4000_0000, 32'h3F80_0000}, out_ready=0 → next cycle count=1, out_valid=1, operands_out equals the input.
- Four simd_doorbell pushes (values 1,2,3,4 in operand 0) with out_ready=0 → count=4 and in_ready=0. A fifth push (value 5) is dropped; with OPQ_OVERFLOW_FLAG_EN, overflow=1. Then drive out_ready=1 for 4 cycles → operand 0 reads 1,2,3,4 in order, then out_valid=0.
- Queue full (DEPTH=4), out_ready=1 and push value 9 in the same cycle → count stays 4, and 9 is delivered after the three remaining entries.
- Queue holding 3 entries, fpu_rst_w=1 and fpu_doorbell_w=1 with enable=0 → next cycle count=1, operands_out=0, out_valid=1.
- enable=0 with fpu_doorbell_w=1 and simd_doorbell=1 → count unchanged and no write; with enable=1 and both strobes high → exactly one entry is added.
- DEPTH=3, NUM_OPERANDS=3: run 10 push/pop cycles to wrap the pointers twice → data order is preserved, and count never exceeds 3. Assert reset mid-stream → count=0 and out_valid=0 asynchronously.
